// File: rtl/s2c_pkg.sv
// Shared constants, codes and state type for the s2c responder slice.
package s2c_pkg;

  localparam int S2C_DATA_SIZE = 16;
  localparam int S2C_PKT_WORDS = S2C_DATA_SIZE + 3;

  // Function codes carried in the fn word.
  localparam logic [31:0] S2C_FN_ECHO  = 32'd0;
  localparam logic [31:0] S2C_FN_SETUP = 32'd1;
  localparam logic [31:0] S2C_FN_SUM   = 32'd2;
  localparam logic [31:0] S2C_FN_INV   = 32'd3;

  // Return codes written into the ret word.
  localparam logic [31:0] S2C_RET_OK      = 32'h0000_0000;
  localparam logic [31:0] S2C_RET_BADFN   = 32'hFFFF_FFFF;
  localparam logic [31:0] S2C_RET_NOSETUP = 32'hFFFF_FFFE;
  localparam logic [31:0] S2C_RET_BADID   = 32'hFFFF_FFFD;

  // Word offsets inside a packet.
  localparam int S2C_OFS_ID   = 0;
  localparam int S2C_OFS_FN   = 1;
  localparam int S2C_OFS_RET  = 2;
  localparam int S2C_OFS_DATA = 3;

  typedef enum logic [1:0] {
    RX   = 2'd0,
    EXEC = 2'd1,
    TX   = 2'd2
  } s2c_state_e;

  // Return code for a finished request. mask_hit already folds in the id
  // range check, so SUM/INV on an out-of-range id report NOSETUP.
  function automatic logic [31:0] s2c_ret_code(
    input logic [31:0] fn,
    input logic        id_ok,
    input logic        mask_hit,
    input logic [31:0] sum
  );
    logic [31:0] r;
    r = S2C_RET_BADFN;
    if (fn == S2C_FN_ECHO) begin
      r = S2C_RET_OK;
    end else if (fn == S2C_FN_SETUP) begin
      r = id_ok ? S2C_RET_OK : S2C_RET_BADID;
    end else if (fn == S2C_FN_SUM) begin
      r = mask_hit ? sum : S2C_RET_NOSETUP;
    end else if (fn == S2C_FN_INV) begin
      r = mask_hit ? S2C_RET_OK : S2C_RET_NOSETUP;
    end
    return r;
  endfunction

endpackage

// File: rtl/s2c_pkt_responder_if.sv
// Request/response word streams between the s2c initiator and responder.
// Handshake: a word moves on a rising edge where valid && ready are both high;
// a source raising valid holds data/last unchanged until that edge, and
// ready may depend combinationally on state but never on valid.
interface s2c_pkt_responder_if;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] rx_data;
  logic        rx_last;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic        tx_last;

  // Initiator side: sends requests, consumes responses.
  modport master (
    output rx_valid, rx_data, rx_last, tx_ready,
    input  rx_ready, tx_valid, tx_data, tx_last
  );

  // Responder side.
  modport slave (
    input  rx_valid, rx_data, rx_last, tx_ready,
    output rx_ready, tx_valid, tx_data, tx_last
  );
endinterface

// File: rtl/s2c_pkt_buf.sv
// Packet register file: one synchronous write port, one combinational read port.
// Contents have no reset; every word is rewritten before it is read out.
module s2c_pkt_buf #(
  parameter int WORDS = 19,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // Single write port shared by RX store and EXEC data/ret update.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/s2c_pkt_responder.sv
// Responder end of the s2c function-call protocol: receive a request packet,
// execute it over a fixed number of cycles, then stream the response back.
module s2c_pkt_responder
  import s2c_pkg::*;
#(
  parameter int DATA_SIZE = S2C_DATA_SIZE,
  parameter int MAX_ID    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  s2c_pkt_responder_if.slave bus,
  output logic              busy,
  output logic              proto_err,
  output logic [MAX_ID-1:0] setup_mask,
  output s2c_state_e        dbg_state
);

  localparam int PKT_WORDS = DATA_SIZE + 3;
  localparam int IDX_W     = $clog2(PKT_WORDS);
  localparam int ID_W      = (MAX_ID > 1) ? $clog2(MAX_ID) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(PKT_WORDS - 1);
  localparam logic [IDX_W-1:0] EXEC_END   = IDX_W'(DATA_SIZE);
  localparam logic [IDX_W-1:0] OFS_DATA_A = IDX_W'(S2C_OFS_DATA);
  localparam logic [IDX_W-1:0] OFS_RET_A  = IDX_W'(S2C_OFS_RET);

  s2c_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       id_q, id_d;
  logic [31:0]       fn_q, fn_d;
  logic [31:0]       sum_q, sum_d;
  logic [MAX_ID-1:0] mask_q, mask_d;
  logic              err_q, err_d;

  logic              buf_we;
  logic [IDX_W-1:0]  buf_waddr;
  logic [31:0]       buf_wdata;
  logic [IDX_W-1:0]  buf_raddr;
  logic [31:0]       buf_rdata;

  logic              rx_ready_c, tx_valid_c, tx_last_c;
  logic [31:0]       tx_data_c;

  logic              id_ok;
  logic              mask_hit;
  logic [ID_W-1:0]   id_idx;

  assign id_ok    = (id_q < 32'(MAX_ID));
  assign id_idx   = id_q[ID_W-1:0];
  assign mask_hit = id_ok && mask_q[id_idx];

  s2c_pkt_buf #(.WORDS(PKT_WORDS), .AW(IDX_W)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (buf_wdata),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  // State, index, captured header and setup bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RX;
      idx_q   <= '0;
      id_q    <= '0;
      fn_q    <= '0;
      sum_q   <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
      fn_q    <= fn_d;
      sum_q   <= sum_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  // Next state, buffer port control and stream outputs.
  // idx is the store index in RX, the data-walk counter in EXEC (the extra
  // step at EXEC_END writes ret) and the emit index in TX.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    id_d       = id_q;
    fn_d       = fn_q;
    sum_d      = sum_q;
    mask_d     = mask_q;
    err_d      = 1'b0;
    buf_we     = 1'b0;
    buf_waddr  = idx_q;
    buf_wdata  = bus.rx_data;
    buf_raddr  = idx_q;
    rx_ready_c = 1'b0;
    tx_valid_c = 1'b0;
    tx_last_c  = 1'b0;
    tx_data_c  = '0;

    case (state_q)
      RX: begin
        rx_ready_c = 1'b1;
        if (bus.rx_valid) begin
          buf_we    = 1'b1;
          buf_waddr = idx_q;
          buf_wdata = bus.rx_data;
          if (idx_q == IDX_W'(S2C_OFS_ID)) id_d = bus.rx_data;
          if (idx_q == IDX_W'(S2C_OFS_FN)) fn_d = bus.rx_data;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (bus.rx_last) begin
              state_d = EXEC;
              sum_d   = '0;
            end else begin
              err_d = 1'b1;
            end
          end else if (bus.rx_last) begin
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      EXEC: begin
        if (idx_q < EXEC_END) begin
          buf_raddr = OFS_DATA_A + idx_q;
          sum_d     = sum_q + buf_rdata;
          if (fn_q == S2C_FN_INV && mask_hit) begin
            buf_we    = 1'b1;
            buf_waddr = OFS_DATA_A + idx_q;
            buf_wdata = ~buf_rdata;
          end
          idx_d = idx_q + 1'b1;
        end else begin
          buf_raddr = '0;
          buf_we    = 1'b1;
          buf_waddr = OFS_RET_A;
          buf_wdata = s2c_ret_code(fn_q, id_ok, mask_hit, sum_q);
          if (fn_q == S2C_FN_SETUP && id_ok) begin
            mask_d[id_idx] = 1'b1;
          end
          idx_d   = '0;
          state_d = TX;
        end
      end

      TX: begin
        tx_valid_c = 1'b1;
        buf_raddr  = idx_q;
        tx_data_c  = buf_rdata;
        tx_last_c  = (idx_q == LAST_IDX);
        if (bus.tx_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = RX;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = RX;
        idx_d   = '0;
      end
    endcase
  end

  assign bus.rx_ready = rx_ready_c;
  assign bus.tx_valid = tx_valid_c;
  assign bus.tx_data  = tx_data_c;
  assign bus.tx_last  = tx_last_c;

  // A packet is in flight once RX has stored a word or the FSM left RX.
  assign busy       = (state_q != RX) || (idx_q != '0);
  assign proto_err  = err_q;
  assign setup_mask = mask_q;
  assign dbg_state  = state_q;

endmodule
